// File: rtl/adc_frame_serializer.sv
// Serialises one captured frame of NumCh x BytesPerCh ADC sample bytes onto a
// byte-wide UART transmit handshake, channel 0 first, each sample MSB byte first.
module adc_frame_serializer #(
    parameter int Width      = 8,
    parameter int NumCh      = 2,
    parameter int BytesPerCh = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [NumCh*Width*BytesPerCh-1:0]   data_i,
    input  logic                                tx_done_i,
    output logic                                tx_start_o,
    output logic [Width-1:0]                    data_o,
    output logic                                busy_o,
    output logic                                done_o
);

    // state | meaning
    // IDLE  | waiting for start_i; frame sample captured on acceptance
    // SEND  | tx_start_o high for this single cycle, data_o holds current byte
    // WAIT  | data_o held, waiting for tx_done_i from the UART
    // DONE  | done_o pulse; busy_o drops on leaving

    localparam int SW = Width * BytesPerCh;
    localparam int NB = NumCh * BytesPerCh;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [NumCh*SW-1:0]    shadow;

    // Frame byte sel: channel sel/BytesPerCh, taken most-significant byte first.
    function automatic logic [Width-1:0] pick_byte(input logic [NumCh*SW-1:0] vec,
                                                   input int sel);
        logic [Width-1:0] res;
        res = '0;
        for (int c = 0; c < NumCh; c++) begin
            for (int b = 0; b < BytesPerCh; b++) begin
                if (c * BytesPerCh + b == sel) begin
                    res = vec[c*SW + (BytesPerCh-1-b)*Width +: Width];
                end
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            idx        <= '0;
            shadow     <= '0;
            tx_start_o <= 1'b0;
            data_o     <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            tx_start_o <= 1'b0;
            done_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        shadow     <= data_i;
                        idx        <= '0;
                        busy_o     <= 1'b1;
                        tx_start_o <= 1'b1;
                        data_o     <= pick_byte(data_i, 0);
                        state      <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done_i) begin
                        if (idx == LastIdx) begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx        <= idx + 1'b1;
                            tx_start_o <= 1'b1;
                            data_o     <= pick_byte(shadow, int'(idx) + 1);
                            state      <= SEND;
                        end
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    idx    <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Self-checking bench for adc_frame_serializer: default 2x2 instance plus a
// 3-channel, 1-byte-per-channel instance, checked against a byte-order model.
module tb_adc_frame_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, tx_done_a, tx_start_a, busy_a, done_a;
    logic [31:0] data_a;
    logic [7:0]  dout_a;

    logic        rst_b, start_b, tx_done_b, tx_start_b, busy_b, done_b;
    logic [23:0] data_b;
    logic [7:0]  dout_b;

    adc_frame_serializer dut_a (
        .clk_i(clk), .rst_i(rst_a), .start_i(start_a), .data_i(data_a),
        .tx_done_i(tx_done_a), .tx_start_o(tx_start_a), .data_o(dout_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    adc_frame_serializer #(.Width(8), .NumCh(3), .BytesPerCh(1)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .start_i(start_b), .data_i(data_b),
        .tx_done_i(tx_done_b), .tx_start_o(tx_start_b), .data_o(dout_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit timed_out;

    logic [7:0] exp_q[$];
    logic [7:0] got_a[$], got_b[$];
    int         st_a[$], st_b[$], dn_a[$], dn_b[$], td_a[$], td_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive recorder; all judging happens in the test tasks.
    always @(negedge clk) begin
        if (tx_start_a) begin got_a.push_back(dout_a); st_a.push_back(cyc); end
        if (done_a)     dn_a.push_back(cyc);
        if (tx_done_a)  td_a.push_back(cyc);
        if (tx_start_b) begin got_b.push_back(dout_b); st_b.push_back(cyc); end
        if (done_b)     dn_b.push_back(cyc);
        if (tx_done_b)  td_b.push_back(cyc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected frame: channel c is the c-th sample of 8*bpc bits, sent high byte first.
    function automatic void model_frame(input logic [31:0] d, input int nch, input int bpc);
        logic [31:0] sample;
        exp_q.delete();
        for (int c = 0; c < nch; c++) begin
            sample = d >> (c * 8 * bpc);
            for (int b = bpc - 1; b >= 0; b--) exp_q.push_back(sample[8*b +: 8]);
        end
    endfunction

    task automatic clear_mon(input bit use_b);
        if (use_b) begin got_b.delete(); st_b.delete(); dn_b.delete(); td_b.delete(); end
        else begin got_a.delete(); st_a.delete(); dn_a.delete(); td_a.delete(); end
    endtask

    // Drives one frame and answers each tx_start with tx_done 'gap' cycles later.
    // poke_at >= 0 pulses start with zero data in the WAIT after that byte, then scrambles data.
    task automatic run_frame(input bit use_b, input logic [31:0] data, input int gap,
                             input int poke_at, input bit hold_start);
        int   cd, seen, poke;
        logic ts, dn;
        cd = 0; seen = 0; poke = 0; timed_out = 1'b1;
        step();
        clear_mon(use_b);
        if (use_b) begin data_b = data[23:0]; start_b = 1'b1; end
        else begin data_a = data; start_a = 1'b1; end
        step();
        if (!hold_start) begin start_a = 1'b0; start_b = 1'b0; end
        for (int i = 0; i < 400; i++) begin
            ts = use_b ? tx_start_b : tx_start_a;
            dn = use_b ? done_b : done_a;
            tx_done_a = 1'b0;
            tx_done_b = 1'b0;
            if (poke == 1) begin
                start_a = 1'b1; data_a = 32'h0; poke = 2;
            end else if (poke == 2) begin
                start_a = 1'b0; data_a = $urandom; poke = 3;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    if (use_b) tx_done_b = 1'b1; else tx_done_a = 1'b1;
                end
            end
            if (ts) begin
                cd = gap;
                if (seen == poke_at) poke = 1;
                seen++;
            end
            if (dn) begin
                timed_out = 1'b0;
                break;
            end
            step();
        end
        tx_done_a = 1'b0;
        tx_done_b = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_seen;
        rst_a = 1'b1; rst_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_a = 1'($urandom); tx_done_a = 1'($urandom); data_a = $urandom;
            start_b = 1'($urandom); tx_done_b = 1'($urandom); data_b = 24'($urandom);
            step();
        end
        n_checks++;
        if (tx_start_a !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", tx_start_a); end
        n_checks++;
        if (dout_a !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", dout_a); end
        n_checks++;
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_checks++;
        if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_a); end
        n_checks++;
        if ({tx_start_b, dout_b, busy_b, done_b} !== 11'h0) begin
            n_fail++; $display("FAIL reset_b_outputs: got %h expected 000", {tx_start_b, dout_b, busy_b, done_b});
        end
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        clear_mon(1'b0);
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tx_done_a = 1'($urandom); data_a = $urandom;
            step();
            if (busy_a) busy_seen++;
        end
        tx_done_a = 1'b0;
        n_checks++;
        if (got_a.size() != 0 || busy_seen != 0) begin
            n_fail++; $display("FAIL reset_no_spontaneous_tx: got %0d tx_start / %0d busy cycles expected 0/0", got_a.size(), busy_seen);
        end
    endtask

    task automatic test_basic_frame();
        model_frame(32'hBEEF_1234, 2, 2);
        run_frame(1'b0, 32'hBEEF_1234, 3, -1, 1'b0);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL basic_timeout: done_o never seen"); end
        n_checks++;
        if (got_a.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d bytes expected 4", got_a.size()); end
        else foreach (exp_q[i]) begin
            n_checks++;
            if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h expected %h", i, got_a[i], exp_q[i]); end
        end
        for (int i = 1; i < st_a.size(); i++) begin
            n_checks++;
            if (st_a[i] - st_a[i-1] != 4) begin n_fail++; $display("FAIL basic_spacing%0d: got %0d expected 4", i, st_a[i] - st_a[i-1]); end
        end
        n_checks++;
        if (dn_a.size() != 1 || td_a.size() == 0 || dn_a[0] != td_a[td_a.size()-1] + 1) begin
            n_fail++; $display("FAIL basic_done_timing: got %0d done pulses expected 1 pulse one cycle after last tx_done", dn_a.size());
        end
        n_checks++;
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_done: got %b expected 1", busy_a); end
        step();
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL basic_after_done: got busy=%b done=%b expected 0/0", busy_a, done_a);
        end
    endtask

    task automatic test_ignore_start_and_data();
        model_frame(32'hBEEF_1234, 2, 2);
        run_frame(1'b0, 32'hBEEF_1234, 3, 1, 1'b0);
        n_checks++;
        if (timed_out || got_a.size() != 4) begin
            n_fail++; $display("FAIL ignore_count: got %0d bytes expected 4 (timeout=%b)", got_a.size(), timed_out);
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL ignore_byte%0d: got %h expected %h", i, got_a[i], exp_q[i]); end
        end
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (got_a.size() != 4 || dn_a.size() != 1 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL ignore_no_second_frame: got %0d bytes %0d done busy=%b expected 4/1/0", got_a.size(), dn_a.size(), busy_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom;
        model_frame(d, 2, 2);
        run_frame(1'b0, d, 1, -1, 1'b0);
        n_checks++;
        if (timed_out || got_a.size() != 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d bytes expected 4 (timeout=%b)", got_a.size(), timed_out);
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_a[i], exp_q[i]); end
        end
        for (int i = 1; i < st_a.size(); i++) begin
            n_checks++;
            if (st_a[i] - st_a[i-1] != 2) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d expected 2", i, st_a[i] - st_a[i-1]); end
        end
        step();
        clear_mon(1'b0);
        tx_done_a = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tx_done_a = 1'b0;
        step();
        n_checks++;
        if (got_a.size() != 0 || dn_a.size() != 0 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL stray_done_idle: got %0d tx_start %0d done busy=%b expected 0/0/0", got_a.size(), dn_a.size(), busy_a);
        end
        d = $urandom;
        model_frame(d, 2, 2);
        run_frame(1'b0, d, 2, -1, 1'b0);
        n_checks++;
        if (timed_out || got_a.size() != 4 || got_a[0] !== exp_q[0] || got_a[3] !== exp_q[3]) begin
            n_fail++; $display("FAIL stray_then_frame: got %0d bytes first %h expected 4 bytes first %h", got_a.size(), got_a.size() > 0 ? got_a[0] : 8'hxx, exp_q[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        step();
        data_a = $urandom; start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        tx_done_a = 1'b1;
        step();
        tx_done_a = 1'b0;
        step();
        n_checks++;
        if (busy_a !== 1'b1 || tx_start_a !== 1'b0) begin
            n_fail++; $display("FAIL midrst_in_wait: got busy=%b tx_start=%b expected 1/0", busy_a, tx_start_a);
        end
        clear_mon(1'b0);
        rst_a = 1'b1;
        step();
        n_checks++;
        if ({tx_start_a, dout_a, busy_a, done_a} !== 11'h0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h expected 000", {tx_start_a, dout_a, busy_a, done_a});
        end
        rst_a = 1'b0;
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (dn_a.size() != 0 || got_a.size() != 0) begin
            n_fail++; $display("FAIL midrst_no_done: got %0d done %0d tx_start expected 0/0", dn_a.size(), got_a.size());
        end
        model_frame(32'hA5A5_0F0F, 2, 2);
        run_frame(1'b0, 32'hA5A5_0F0F, 2, -1, 1'b0);
        n_checks++;
        if (timed_out || got_a.size() != 4) begin
            n_fail++; $display("FAIL midrst_restart_count: got %0d bytes expected 4 (timeout=%b)", got_a.size(), timed_out);
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (got_a[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_byte%0d: got %h expected %h", i, got_a[i], exp_q[i]); end
        end
    endtask

    task automatic test_three_channel();
        model_frame(32'h0033_2211, 3, 1);
        run_frame(1'b1, 32'h0033_2211, 2, -1, 1'b1);
        n_checks++;
        if (timed_out || got_b.size() != 3) begin
            n_fail++; $display("FAIL ch3_count: got %0d bytes expected 3 (timeout=%b)", got_b.size(), timed_out);
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (got_b[i] !== exp_q[i]) begin n_fail++; $display("FAIL ch3_byte%0d: got %h expected %h", i, got_b[i], exp_q[i]); end
        end
        for (int i = 0; i < 10 && st_b.size() < 4; i++) step();
        n_checks++;
        if (st_b.size() != 4 || dn_b.size() != 1 || st_b[3] != dn_b[0] + 2) begin
            n_fail++; $display("FAIL ch3_held_start_restart: got %0d starts %0d done expected restart 2 cycles after done", st_b.size(), dn_b.size());
        end
        start_b = 1'b0;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
    endtask

    task automatic test_random_frames();
        logic [31:0] d;
        int          gap, bad;
        for (int f = 0; f < 8; f++) begin
            bit use_b;
            use_b = (f % 3 == 2);
            d = use_b ? {8'h00, 24'($urandom)} : $urandom;
            gap = $urandom_range(1, 5);
            if (use_b) model_frame(d, 3, 1); else model_frame(d, 2, 2);
            run_frame(use_b, d, gap, -1, 1'b0);
            bad = 0;
            foreach (exp_q[i]) begin
                if (use_b) begin if (i >= got_b.size() || got_b[i] !== exp_q[i]) bad++; end
                else begin if (i >= got_a.size() || got_a[i] !== exp_q[i]) bad++; end
            end
            n_checks++;
            if (timed_out || bad != 0 || (use_b ? got_b.size() : got_a.size()) != exp_q.size()) begin
                n_fail++; $display("FAIL random_frame%0d: got %0d wrong bytes (timeout=%b) expected 0 for data %h gap %0d", f, bad, timed_out, d, gap);
            end
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) step();
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; tx_done_a = 1'b0; data_a = '0;
        start_b = 1'b0; tx_done_b = 1'b0; data_b = '0;
        test_reset();
        test_basic_frame();
        test_ignore_start_and_data();
        test_back_to_back();
        test_reset_mid_frame();
        test_three_channel();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
